eth_pixel_writer: RTL and testbench



---
 rtl/eth_pixel_writer_pkg.sv | 23 ++
 rtl/eth_pixel_writer.sv | 162 ++++++++++++++++
 tb/tb_eth_pixel_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pixel_writer_pkg.sv
// Shared definitions for the Ethernet pixel writer: FSM state encoding and RGB332 field layout.
package eth_pixel_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW   = 2'd1,
        ST_PIX   = 2'd2,
        ST_DRAIN = 2'd3
    } pix_state_e;

    localparam int RGB_R_LSB = 5;
    localparam int RGB_R_W   = 3;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_G_W   = 3;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_B_W   = 2;

    // Payload bytes already arrive as RGB332; this makes the field layout explicit.
    function automatic logic [7:0] rgb332_pack(input logic [7:0] px);
        return {px[RGB_R_LSB +: RGB_R_W], px[RGB_G_LSB +: RGB_G_W], px[RGB_B_LSB +: RGB_B_W]};
    endfunction

endpackage

// File: rtl/eth_pixel_writer.sv
// Filters frames by MAC/EtherType and writes one row of RGB332 pixels per frame; writes and pulses
// are registered (1 cycle after the beat), one pixel per cycle, headers held off outside IDLE.
module eth_pixel_writer
    import eth_pixel_writer_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'hDAD1D2D3D4D5,
    parameter logic [15:0] ETH_TYPE = 16'h88B5,
    parameter int          ROWS     = 32,
    parameter int          COLS     = 64,
    localparam int         RW       = $clog2(ROWS),
    localparam int         CW       = $clog2(COLS),
    localparam int         AW       = RW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hdr_valid,
    output logic          hdr_ready,
    input  logic [47:0]   dest_mac,
    input  logic [15:0]   eth_type,
    input  logic [7:0]    s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic          s_tuser,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_wdata,
    output logic          row_done,
    output logic          err_short,
    output logic          err_row,
    output logic          err_bad
);

    localparam logic [7:0]    ROWS_B   = 8'(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    pix_state_e    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          acc_q, acc_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          eshort_q, eshort_d;
    logic          erow_q, erow_d;
    logic          ebad_q, ebad_d;
    logic          beat;
    logic          bad_end;

    assign hdr_ready = (state_q == ST_IDLE);
    assign s_tready  = (state_q != ST_IDLE);
    assign beat      = s_tvalid && s_tready;
    // err_bad only reports on frames we actually claimed at the header.
    assign bad_end   = beat && s_tlast && s_tuser && acc_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        acc_d    = acc_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        eshort_d = 1'b0;
        erow_d   = 1'b0;
        ebad_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdr_valid) begin
                    if (dest_mac == MAC_ADDR && eth_type == ETH_TYPE) begin
                        acc_d   = 1'b1;
                        state_d = ST_ROW;
                    end else begin
                        acc_d   = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_ROW: begin
                if (beat) begin
                    row_d  = s_tdata[RW-1:0];
                    col_d  = '0;
                    ebad_d = bad_end;
                    if (s_tlast) begin
                        eshort_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (s_tdata >= ROWS_B) begin
                        erow_d  = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_PIX;
                    end
                end
            end
            ST_PIX: begin
                if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = {row_q, col_q};
                    wdata_d = rgb332_pack(s_tdata);
                    ebad_d  = bad_end;
                    if (col_q == COL_LAST) begin
                        done_d  = 1'b1;
                        state_d = s_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                        if (s_tlast) begin
                            eshort_d = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && s_tlast) begin
                    ebad_d  = bad_end;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            acc_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            eshort_q <= 1'b0;
            erow_q   <= 1'b0;
            ebad_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            acc_q    <= acc_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            eshort_q <= eshort_d;
            erow_q   <= erow_d;
            ebad_q   <= ebad_d;
        end
    end

    assign fb_we     = we_q;
    assign fb_addr   = addr_q;
    assign fb_wdata  = wdata_q;
    assign row_done  = done_q;
    assign err_short = eshort_q;
    assign err_row   = erow_q;
    assign err_bad   = ebad_q;

endmodule

// File: tb/tb_eth_pixel_writer.sv
// Directed and randomized frames driven into eth_pixel_writer, checked against a per-frame model.
module tb_eth_pixel_writer;

    localparam logic [47:0] MAC  = 48'hDAD1D2D3D4D5;
    localparam logic [15:0] ET   = 16'h88B5;
    localparam int          ROWS = 32;
    localparam int          COLS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [47:0] dest_mac = '0;
    logic [15:0] eth_type = '0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        row_done, err_short, err_row, err_bad;

    always #5 clk = ~clk;

    eth_pixel_writer dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .dest_mac(dest_mac), .eth_type(eth_type),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .row_done(row_done), .err_short(err_short), .err_row(err_row), .err_bad(err_bad)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [18:0] got_wr[$];
    int n_done = 0, n_short = 0, n_row = 0, n_bad = 0;
    int done_cyc = 0, bad_cyc = 0;

    logic [7:0]  fr[$];
    logic [18:0] exp_wr[$];
    int e_done, e_short, e_row, e_bad;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_we) got_wr.push_back({fb_addr, fb_wdata});
            if (row_done) begin n_done++; done_cyc = cyc; end
            if (err_short) n_short++;
            if (err_row) n_row++;
            if (err_bad) begin n_bad++; bad_cyc = cyc; end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Builds the payload: row byte, then n pixel/padding bytes (counting up or random).
    task automatic mk_frame(input int row, input int n, input bit seq);
        fr.delete();
        fr.push_back(8'(row));
        for (int i = 0; i < n; i++) fr.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // Expected outcome of one whole frame, straight from the payload rules.
    task automatic model(input logic acc, input logic tuser);
        int np;
        exp_wr.delete();
        e_done = 0; e_short = 0; e_row = 0; e_bad = 0;
        if (!acc) return;
        e_bad = int'(tuser);
        if (fr.size() == 1) begin
            e_short = 1;
        end else if (int'(fr[0]) >= ROWS) begin
            e_row = 1;
        end else begin
            np = (fr.size() - 1 > COLS) ? COLS : fr.size() - 1;
            for (int k = 0; k < np; k++)
                exp_wr.push_back({11'(int'(fr[0]) * COLS + k), fr[k + 1]});
            if (fr.size() - 1 >= COLS) e_done = 1;
            else e_short = 1;
        end
    endtask

    task automatic send_frame(input logic [47:0] mac, input logic [15:0] et,
                              input logic tuser, input int abort_at);
        int wb, bd, bs, br, bb, stalls, tmo;
        logic [18:0] g;
        model(mac == MAC && et == ET, tuser);
        wb = got_wr.size(); bd = n_done; bs = n_short; br = n_row; bb = n_bad;
        @(negedge clk);
        hdr_valid = 1'b1; dest_mac = mac; eth_type = et;
        tmo = 0;
        while (!hdr_ready && tmo < 20) begin @(negedge clk); tmo++; end
        chk("hdr_accept_timeout", 64'(tmo < 20), 64'd1);
        @(negedge clk);
        hdr_valid = 1'b0;
        stalls = 0;
        for (int i = 0; i < fr.size(); i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
                #1;
                chk("rst_fb_we", 64'(fb_we), 64'd0);
                chk("rst_hdr_ready", 64'(hdr_ready), 64'd1);
                chk("rst_s_tready", 64'(s_tready), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            s_tvalid = 1'b1;
            s_tdata  = fr[i];
            s_tlast  = (i == fr.size() - 1);
            s_tuser  = (i == fr.size() - 1) ? tuser : 1'($urandom_range(0, 1));
            tmo = 0;
            while (!s_tready && tmo < 20) begin @(negedge clk); stalls++; tmo++; end
            @(negedge clk);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        chk("hdr_ready_after_last", 64'(hdr_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("stall_cycles", 64'(stalls), 64'd0);
        chk("write_count", 64'(got_wr.size() - wb), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size(); k++) begin
            g = (wb + k < got_wr.size()) ? got_wr[wb + k] : 19'h7FFFF;
            chk("write_addr_data", 64'(g), 64'(exp_wr[k]));
        end
        chk("row_done_count", 64'(n_done - bd), 64'(e_done));
        chk("err_short_count", 64'(n_short - bs), 64'(e_short));
        chk("err_row_count", 64'(n_row - br), 64'(e_row));
        chk("err_bad_count", 64'(n_bad - bb), 64'(e_bad));
    endtask

    initial begin
        logic [47:0] m;
        logic [15:0] t;

        repeat (3) @(negedge clk);
        chk("reset_hdr_ready", 64'(hdr_ready), 64'd1);
        chk("reset_s_tready", 64'(s_tready), 64'd0);
        chk("reset_fb_we", 64'(fb_we), 64'd0);
        chk("reset_fb_addr", 64'(fb_addr), 64'd0);
        chk("reset_fb_wdata", 64'(fb_wdata), 64'd0);
        chk("reset_pulses", 64'({row_done, err_short, err_row, err_bad}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mk_frame(5, 64, 1'b1);
        send_frame(MAC, ET, 1'b0, -1);

        mk_frame(5, 64, 1'b0);
        send_frame(48'h001122334455, ET, 1'b0, -1);

        mk_frame(32, 64, 1'b0);
        send_frame(MAC, ET, 1'b0, -1);

        mk_frame(0, 10, 1'b0);
        send_frame(MAC, ET, 1'b0, -1);

        mk_frame(31, 74, 1'b0);
        send_frame(MAC, ET, 1'b1, -1);
        chk("bad_after_padding", 64'(bad_cyc - done_cyc), 64'd10);

        mk_frame(9, 64, 1'b0);
        send_frame(MAC, ET, 1'b0, 21);
        mk_frame(7, 64, 1'b0);
        send_frame(MAC, ET, 1'b0, -1);

        mk_frame(3, 0, 1'b0);
        send_frame(MAC, ET, 1'b1, -1);

        for (int f = 0; f < 40; f++) begin
            m = MAC;
            t = ET;
            if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 47)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) t[$urandom_range(0, 15)] ^= 1'b1;
            mk_frame($urandom_range(0, 40), $urandom_range(0, 80), 1'b0);
            send_frame(m, t, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
